// File: rtl/alu_op_sequencer.sv
// Issues one op at a time to the ALU: decodes the opcode to one-hot control, holds
// operands for the ALU latency, captures the result and returns it on a response channel.
module alu_op_sequencer #(
   parameter int WIDTH       = 4,
   parameter int ALU_LATENCY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_overflow,
   output logic             rsp_err,
   output logic             busy,
   output logic [8:0]       alu_ctrl,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_overflow
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_LSR = 4'd2;
   localparam logic [3:0] OP_MAX = 4'd8;

   state_t           r_state;
   state_t           w_state_next;
   logic [2:0]       r_cnt;
   logic [2:0]       w_cnt_next;
   logic [3:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic             r_ovf;
   logic             r_err;
   logic             w_accept;
   logic             w_legal;
   logic             w_capture;

   assign w_legal   = (req_op <= OP_MAX);
   assign w_accept  = (r_state == S_IDLE) && req_valid;
   assign w_capture = (r_state == S_EXEC) && (r_cnt == 3'd0);

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      req_ready    = 1'b0;
      rsp_valid    = 1'b0;
      busy         = 1'b1;
      alu_ctrl     = '0;
      alu_in1      = '0;
      alu_in2      = '0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               if (w_legal) begin
                  w_state_next = S_EXEC;
                  w_cnt_next   = 3'(ALU_LATENCY);
               end else begin
                  w_state_next = S_RESP;
               end
            end
         end
         S_EXEC: begin
            // r_op is only ever latched from a legal opcode, so this stays one-hot
            alu_ctrl = 9'd1 << r_op;
            alu_in1  = r_a;
            alu_in2  = r_b;
            if (r_cnt == 3'd0) begin
               w_state_next = S_RESP;
            end else begin
               w_cnt_next = r_cnt - 3'd1;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_ovf    <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            if (w_legal) begin
               r_op <= req_op;
               r_a  <= req_a;
               r_b  <= req_b;
            end else begin
               r_result <= '0;
               r_ovf    <= 1'b0;
               r_err    <= 1'b1;
            end
         end
         if (w_capture) begin
            // LSR only loads the ALU shift register; its out port carries nothing useful
            r_result <= (r_op == OP_LSR) ? r_a : alu_out;
            r_ovf    <= ((r_op == OP_ADD) || (r_op == OP_SUB)) ? alu_overflow : 1'b0;
            r_err    <= 1'b0;
         end
      end
   end

   assign rsp_result   = r_result;
   assign rsp_overflow = r_ovf;
   assign rsp_err      = r_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a small behavioural ALU, directed ops, and a queue of
// expected responses checked as each response appears.
module tb_alu_op_sequencer;

   localparam int W = 4;
   localparam int L = 1;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [3:0]   req_op = '0;
   logic [W-1:0] req_a = '0;
   logic [W-1:0] req_b = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b1;
   logic [W-1:0] rsp_result;
   logic         rsp_overflow;
   logic         rsp_err;
   logic         busy;
   logic [8:0]   alu_ctrl;
   logic [W-1:0] alu_in1;
   logic [W-1:0] alu_in2;
   logic [W-1:0] alu_out = '0;
   logic         alu_overflow = 1'b0;
   logic [W-1:0] alu_shreg = '0;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [W-1:0] res;
      logic         ovf;
      logic         err;
      logic [8:0]   ctrl;
      int           lat;
      int           cc;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   alu_op_sequencer #(.WIDTH(W), .ALU_LATENCY(L)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_overflow(rsp_overflow), .rsp_err(rsp_err), .busy(busy),
      .alu_ctrl(alu_ctrl), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_out(alu_out), .alu_overflow(alu_overflow)
   );

   // Behavioural ALU with a one-edge latency; overflow is driven high on
   // non-arithmetic ops so that the sequencer's masking is exercised.
   always @(posedge clk) begin
      case (alu_ctrl)
         9'h001: {alu_overflow, alu_out} <= {1'b0, alu_in1} + {1'b0, alu_in2};
         9'h002: begin alu_out <= alu_in1 - alu_in2; alu_overflow <= (alu_in1 >= alu_in2); end
         9'h004: begin alu_shreg <= alu_in1; alu_out <= 4'hF; alu_overflow <= 1'b1; end
         9'h008: begin alu_out <= alu_in1 << 1; alu_overflow <= 1'b1; end
         9'h010: begin alu_out <= alu_in1 >> 1; alu_overflow <= 1'b1; end
         9'h020: begin alu_out <= alu_in1 & alu_in2; alu_overflow <= 1'b1; end
         9'h040: begin alu_out <= alu_in1 | alu_in2; alu_overflow <= 1'b1; end
         9'h080: begin alu_out <= alu_in1 ^ alu_in2; alu_overflow <= 1'b1; end
         9'h100: begin alu_out <= ~alu_in1; alu_overflow <= 1'b1; end
         default: begin alu_out <= '0; alu_overflow <= 1'b0; end
      endcase
   end

   function automatic exp_t expect_of(input logic [3:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
      exp_t e;
      logic [W:0] s;
      e.ovf  = 1'b0;
      e.err  = 1'b0;
      e.res  = '0;
      e.ctrl = '0;
      e.lat  = L + 2;
      e.cc   = L + 1;
      case (op)
         4'd0: begin s = {1'b0, a} + {1'b0, b}; e.res = s[W-1:0]; e.ovf = s[W]; end
         4'd1: begin e.res = a - b; e.ovf = (a >= b); end
         4'd2: e.res = a;
         4'd3: e.res = a << 1;
         4'd4: e.res = a >> 1;
         4'd5: e.res = a & b;
         4'd6: e.res = a | b;
         4'd7: e.res = a ^ b;
         4'd8: e.res = ~a;
         default: begin e.err = 1'b1; e.lat = 1; e.cc = 0; end
      endcase
      if (op <= 4'd8) e.ctrl = 9'd1 << op;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issues one op, checks control/latency while it runs, then compares the response
   // against the scoreboard. hold>0 keeps rsp_ready low and offers a competing request.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int hold);
      exp_t e;
      int k;
      int ctrl_cyc;
      bit ctrl_bad;
      bit seen;
      logic [W-1:0] hres;
      @(negedge clk);
      chk({tag, ".req_ready"}, 16'(req_ready), 16'd1);
      sb.push_back(expect_of(op, a, b));
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      rsp_ready = (hold == 0);
      @(negedge clk);
      req_valid = 1'b0;
      k = 1; seen = 0; ctrl_cyc = 0; ctrl_bad = 0;
      while (!seen && k <= 20) begin
         if (alu_ctrl != 9'd0) ctrl_cyc++;
         if (!$onehot0(alu_ctrl)) ctrl_bad = 1;
         if (rsp_valid === 1'b1) seen = 1;
         else begin @(negedge clk); k++; end
      end
      e = sb.pop_front();
      if (e.ctrl != 9'd0 && ctrl_cyc == 0) ctrl_bad = 1;
      chk({tag, ".rsp_seen"}, 16'(seen), 16'd1);
      chk({tag, ".latency"}, 16'(k), 16'(e.lat));
      chk({tag, ".ctrl_cycles"}, 16'(ctrl_cyc), 16'(e.cc));
      chk({tag, ".ctrl_onehot"}, 16'(ctrl_bad), 16'd0);
      chk({tag, ".result"}, 16'(rsp_result), 16'(e.res));
      chk({tag, ".overflow"}, 16'(rsp_overflow), 16'(e.ovf));
      chk({tag, ".err"}, 16'(rsp_err), 16'(e.err));
      if (hold > 0) begin
         hres = rsp_result;
         req_valid = 1'b1; req_op = 4'd0; req_a = 4'd1; req_b = 4'd1;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 16'(rsp_valid), 16'd1);
            chk({tag, ".hold_result"}, 16'(rsp_result), 16'(hres));
            chk({tag, ".hold_req_ready"}, 16'(req_ready), 16'd0);
            chk({tag, ".hold_ctrl"}, 16'(alu_ctrl), 16'd0);
         end
         req_valid = 1'b0;
         rsp_ready = 1'b1;
      end
      @(negedge clk);
      chk({tag, ".rsp_drop"}, 16'(rsp_valid), 16'd0);
      chk({tag, ".idle"}, 16'(busy), 16'd0);
      $display("TXN %s op=%0h a=%0h b=%0h result=%0h ovf=%0b err=%0b latency=%0d",
               tag, op, a, b, rsp_result, rsp_overflow, rsp_err, k);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] t2_ops [7];
      t2_ops = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};

      repeat (2) @(negedge clk);
      chk("RST.ctrl_in_reset", 16'(alu_ctrl), 16'd0);
      chk("RST.valid_in_reset", 16'(rsp_valid), 16'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("RST.req_ready", 16'(req_ready), 16'd1);
      chk("RST.busy", 16'(busy), 16'd0);
      chk("RST.result", 16'(rsp_result), 16'd0);
      chk("RST.err", 16'(rsp_err), 16'd0);

      run_op("T1_ADD", 4'd0, 4'd7, 4'd5, 0);
      chk("T1.result_const", 16'(rsp_result), 16'hC);
      foreach (t2_ops[i]) run_op($sformatf("T2_op%0d", t2_ops[i]), t2_ops[i], 4'd7, 4'd5, 0);
      run_op("T3_LSR", 4'd2, 4'd7, 4'd5, 0);
      chk("T3.shreg", 16'(alu_shreg), 16'h7);
      run_op("B_ADDCARRY", 4'd0, 4'd9, 4'd9, 0);
      run_op("B_SUBBORROW", 4'd1, 4'd3, 4'd5, 0);
      run_op("T4_ILLEGAL_A", 4'hA, 4'd7, 4'd5, 0);
      run_op("B_ILLEGAL_F", 4'hF, 4'd3, 4'd3, 0);
      run_op("T5_ADD_HOLD", 4'd0, 4'd7, 4'd5, 5);
      run_op("T5_SECOND", 4'd7, 4'd6, 4'd3, 0);

      @(negedge clk);
      req_valid = 1'b1; req_op = 4'd0; req_a = 4'd9; req_b = 4'd9;
      @(negedge clk);
      req_valid = 1'b0;
      chk("T6.busy_exec", 16'(busy), 16'd1);
      #2 reset = 1'b0;
      #1;
      chk("T6.ctrl_abort", 16'(alu_ctrl), 16'd0);
      chk("T6.busy_abort", 16'(busy), 16'd0);
      chk("T6.valid_abort", 16'(rsp_valid), 16'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("T6.req_ready", 16'(req_ready), 16'd1);
      chk("T6.no_rsp", 16'(rsp_valid), 16'd0);
      run_op("T6_ADD", 4'd0, 4'd3, 4'd4, 0);
      chk("T6.result_const", 16'(rsp_result), 16'h7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
